// File: rtl/i2s_pkg.sv
// i2s_pkg: clock ratios, sample phase and channel encoding shared by the I2S receive and transmit paths.
package i2s_pkg;
  localparam int DATA_W = 16;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 4;
  localparam int LRCLK_BIT = 9;
  localparam logic [SCLK_BIT:0] SAMPLE_PHASE = 5'b11000;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: free-running divider producing mclk/sclk/lrclk plus the mid-sclk-high sample strobe.
import i2s_pkg::*;
module i2s_clkgen (
  input  logic       clk,
  input  logic       rst,
  output logic       mclk,
  output logic       sclk,
  output logic       lrclk,
  output logic       strobe,
  output logic       frame_start,
  output logic [3:0] slot,
  output logic       half
);
  logic [LRCLK_BIT:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  assign mclk = cnt_q[MCLK_BIT];
  assign sclk = cnt_q[SCLK_BIT];
  assign lrclk = cnt_q[LRCLK_BIT];
  assign strobe = cnt_q[SCLK_BIT:0] == SAMPLE_PHASE;
  assign frame_start = cnt_q == '0;
  assign slot = cnt_q[LRCLK_BIT-1:SCLK_BIT+1];
  assign half = cnt_q[LRCLK_BIT];
endmodule

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S clock master that deserializes codec ADC data into left/right pairs on a valid/ready port.
import i2s_pkg::*;
module i2s_rx_capture (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i2s_sdout,
  output logic              i2s_mclk,
  output logic              i2s_sclk,
  output logic              i2s_lrclk,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr
);
  logic strobe, frame_start, half;
  logic [3:0] slot;
  logic sdin_q, valid_q, valid_d, overrun_q, overrun_d, armed_q, armed_d, left_ok_q, left_ok_d;
  logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d, left_q, left_d, right_q, right_d;
  logic word_done, left_done, right_done, pair_done, load;
  ch_e ch;
  i2s_clkgen u_clkgen (
    .clk(clk), .rst(rst), .mclk(i2s_mclk), .sclk(i2s_sclk), .lrclk(i2s_lrclk),
    .strobe(strobe), .frame_start(frame_start), .slot(slot), .half(half)
  );
  // The word finishing in slot 0 belongs to the previous half (one-bit I2S delay).
  assign ch = half ? CH_LEFT : CH_RIGHT;
  assign word_done = strobe && slot == 4'd0;
  assign left_done = word_done && ch == CH_LEFT && armed_q;
  assign right_done = word_done && ch == CH_RIGHT;
  assign pair_done = right_done && armed_q && left_ok_q;
  assign load = pair_done && (!valid_q || out_ready);
  always_comb begin
    shift_d = strobe ? {shift_q[DATA_W-2:0], sdin_q} : shift_q;
    hold_d = left_done ? shift_d : hold_q;
    left_d = load ? hold_q : left_q;
    right_d = load ? shift_d : right_q;
    valid_d = load || (valid_q && !out_ready);
    overrun_d = overrun_clr ? 1'b0 : (overrun_q || (pair_done && !load));
    armed_d = en && (armed_q || frame_start);
    // A pair only counts if its left word was captured after arming.
    left_ok_d = !en ? 1'b0 : left_done ? 1'b1 : right_done ? 1'b0 : left_ok_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sdin_q <= 1'b0;
      shift_q <= '0;
      hold_q <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      armed_q <= 1'b0;
      left_ok_q <= 1'b0;
    end else begin
      sdin_q <= i2s_sdout;
      shift_q <= shift_d;
      hold_q <= hold_d;
      left_q <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      armed_q <= armed_d;
      left_ok_q <= left_ok_d;
    end
  assign left_data = left_q;
  assign right_data = right_q;
  assign out_valid = valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_i2s_rx_capture.sv
// tb_i2s_rx_capture: directed checks of the I2S receiver against a frame-indexed codec model.
module tb_i2s_rx_capture;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, sd, out_ready = 1'b0, overrun_clr = 1'b0;
  logic mclk, sclk, lrclk, out_valid, overrun;
  logic [15:0] left_data, right_data;
  logic [9:0] tc;
  logic [3:0] fn;
  logic [15:0] lw [0:15];
  logic [15:0] rw [0:15];
  int n_asrt = 0, n_fail = 0;
  i2s_rx_capture dut (
    .clk(clk), .rst(rst), .en(en), .i2s_sdout(sd), .i2s_mclk(mclk), .i2s_sclk(sclk),
    .i2s_lrclk(lrclk), .left_data(left_data), .right_data(right_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );
  always #5 clk = ~clk;
  // Codec timeline: cycle count within frame and frame number, restarted by reset.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tc <= '0;
      fn <= '0;
    end else begin
      tc <= tc + 1'b1;
      if (tc == 10'd1023) fn <= fn + 1'b1;
    end
  always_comb begin
    logic [3:0] s;
    logic [3:0] pf;
    s = tc[8:5];
    pf = fn - 1'b1;
    sd = 1'b0;
    if (s != 4'd0) sd = tc[9] ? rw[fn][16-s] : lw[fn][16-s];
    else sd = tc[9] ? lw[fn][0] : rw[pf][0];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic at(input int f, input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(fn) == f && int'(tc) == c) && n < 5000);
    chk($sformatf("reach f%0d c%0d", f, c), {fn, tc}, {f[3:0], c[9:0]});
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      lw[i] = '0;
      rw[i] = '0;
    end
    lw[0] = 16'hDEAD; rw[0] = 16'hBEEF;
    lw[1] = 16'hA5C3; rw[1] = 16'h1234;
    lw[2] = 16'h0001; rw[2] = 16'h0002;
    lw[3] = 16'h0003; rw[3] = 16'h0004;
    lw[4] = 16'h0005; rw[4] = 16'h0006;
    lw[5] = 16'h0007; rw[5] = 16'h0008;
    lw[6] = 16'h0009; rw[6] = 16'h000A;
    repeat (5) @(negedge clk);
    chk("rst clocks", {mclk, sclk, lrclk}, 0);
    chk("rst data", {left_data, right_data}, 0);
    chk("rst flags", {out_valid, overrun}, 0);
    rst = 1'b1;
    at(0, 2);  chk("mclk hi", mclk, 1);
    at(0, 4);  chk("mclk lo", mclk, 0);
    at(0, 15); chk("sclk 15", sclk, 0);
    at(0, 16); chk("sclk 16", sclk, 1);
    at(0, 32); chk("sclk 32", sclk, 0);
    at(0, 300);
    en = 1'b1;
    at(0, 511); chk("lrclk 511", lrclk, 0);
    at(0, 512); chk("lrclk 512", lrclk, 1);
    at(1, 25); chk("midframe en no valid", out_valid, 0);
    at(2, 24); chk("pre latency", out_valid, 0);
    at(2, 25); chk("single valid", out_valid, 1);
    chk("single data", {left_data, right_data}, 32'hA5C3_1234);
    at(2, 100);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop", out_valid, 0);
    at(3, 25); chk("bp valid", out_valid, 1);
    chk("bp data1", {left_data, right_data}, 32'h0001_0002);
    at(4, 24); chk("no overrun yet", overrun, 0);
    at(4, 25); chk("overrun set", overrun, 1);
    chk("bp data held", {left_data, right_data, 15'd0, out_valid}, {32'h0001_0002, 16'd1});
    at(4, 100);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun clr", overrun, 0);
    at(5, 24);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("clr priority", overrun, 0);
    chk("drop keeps data", {left_data, right_data}, 32'h0001_0002);
    at(6, 24);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop+load valid", out_valid, 1);
    chk("pop+load data", {left_data, right_data}, 32'h0007_0008);
    chk("pop+load no overrun", overrun, 0);
    at(6, 700);
    rst = 1'b0;
    #1;
    chk("midreset flags", {out_valid, overrun}, 0);
    chk("midreset data", {left_data, right_data}, 0);
    lw[0] = 16'h8000; rw[0] = 16'h7FFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    at(0, 25); chk("post reset no stale", out_valid, 0);
    at(1, 24); chk("post reset pre", out_valid, 0);
    at(1, 25); chk("post reset valid", out_valid, 1);
    chk("post reset data", {left_data, right_data}, 32'h8000_7FFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
